// File: rtl/encoder_8_3_serializer.sv
// ---------------------------------------------------------------------------
// encoder_8_3_serializer
//
// Purpose: takes an 8-bit multi-hot request vector over a valid/ready
// handshake and emits one 3-bit binary index per set bit, in priority
// order, over a second valid/ready handshake. An all-zero vector produces
// a single beat flagged with out_zero.
//
// Parameters:
//   LSB_FIRST  1 = lowest set bit emitted first, 0 = highest set bit first
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_vec is valid this cycle
//   in_ready   block can accept in_vec this cycle (combinational)
//   in_vec     multi-hot request vector
//   out_valid  out_code / out_last / out_zero are valid
//   out_ready  consumer accepts the current beat
//   out_code   binary index of the current set bit
//   out_last   current beat is the final beat of its vector
//   out_zero   accepted vector was all zero (out_code = 0)
// ---------------------------------------------------------------------------
module encoder_8_3_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the set bit that goes out next, according to LSB_FIRST.
  function automatic logic [2:0] pri_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  state_t     state_q, state_d;
  // Bits still to be emitted after the beat currently on the output.
  logic [7:0] rest_q, rest_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_code_q, out_code_d;
  logic       out_last_q, out_last_d;
  logic       out_zero_q, out_zero_d;

  logic       accept_s;
  logic       xfer_s;
  logic [7:0] src_s;
  logic [2:0] next_code_s;
  logic [7:0] next_rest_s;

  // A new vector can enter when idle, or on the edge that retires the
  // final beat of the current vector, so vectors stream without bubbles.
  assign in_ready = !reset && ((state_q == IDLE) ||
                               (out_valid_q && out_ready && out_last_q));

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;

  // Next-state and next-beat computation.
  always_comb begin
    accept_s    = in_valid && in_ready;
    xfer_s      = out_valid_q && out_ready;
    // The next beat comes from the fresh vector on acceptance, otherwise
    // from what remains of the held one.
    src_s       = accept_s ? in_vec : rest_q;
    next_code_s = pri_idx(src_s);
    next_rest_s = src_s & ~(8'h01 << next_code_s);

    state_d     = state_q;
    rest_d      = rest_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_last_d  = out_last_q;
    out_zero_d  = out_zero_q;

    if (accept_s) begin
      state_d     = EMIT;
      out_valid_d = 1'b1;
      if (in_vec != 8'h00) begin
        out_code_d = next_code_s;
        rest_d     = next_rest_s;
        out_last_d = (next_rest_s == 8'h00);
        out_zero_d = 1'b0;
      end else begin
        out_code_d = 3'd0;
        rest_d     = 8'h00;
        out_last_d = 1'b1;
        out_zero_d = 1'b1;
      end
    end else if (xfer_s) begin
      if (out_last_q) begin
        state_d     = IDLE;
        rest_d      = 8'h00;
        out_valid_d = 1'b0;
        out_code_d  = 3'd0;
        out_last_d  = 1'b0;
        out_zero_d  = 1'b0;
      end else begin
        out_code_d = next_code_s;
        rest_d     = next_rest_s;
        out_last_d = (next_rest_s == 8'h00);
        out_zero_d = 1'b0;
      end
    end else begin
      // Idle or back-pressured: everything holds.
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any in-flight vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rest_q      <= 8'h00;
      out_valid_q <= 1'b0;
      out_code_q  <= 3'd0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rest_q      <= rest_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_encoder_8_3_serializer.sv
module tb_encoder_8_3_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, out_last_a, out_zero_a;
  logic [2:0] out_code_a;
  logic       in_ready_b, out_valid_b, out_last_b, out_zero_b;
  logic [2:0] out_code_b;

  // Both orderings share the stimulus; beat counts match so timing matches.
  encoder_8_3_serializer #(.LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_vec(in_vec), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_code(out_code_a), .out_last(out_last_a), .out_zero(out_zero_a)
  );

  encoder_8_3_serializer #(.LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_vec(in_vec), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_code(out_code_b), .out_last(out_last_b), .out_zero(out_zero_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] code;
    logic       last;
    logic       zero;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    log_a[$];
  int    log_b[$];
  int    checks = 0;
  int    failures = 0;
  bit    started = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected beat list of a vector: one entry per set bit in each order.
  function automatic void push_vec(input logic [7:0] v);
    int n;
    int k;
    n = $countones(v);
    if (n == 0) begin
      qa.push_back('{code: 3'd0, last: 1'b1, zero: 1'b1});
      qb.push_back('{code: 3'd0, last: 1'b1, zero: 1'b1});
    end else begin
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          k++;
          qa.push_back('{code: 3'(i), last: (k == n), zero: 1'b0});
        end
      end
      k = 0;
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin
          k++;
          qb.push_back('{code: 3'(i), last: (k == n), zero: 1'b0});
        end
      end
    end
  endfunction

  // Reference model: head of each queue is the beat on the output.
  always @(posedge clk) begin
    bit ir;
    started = 1'b1;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      ir = (qa.size() == 0) || (out_ready && qa[0].last);
      if (qa.size() != 0 && out_ready) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (in_valid && ir) push_vec(in_vec);
    end
  end

  // Per-cycle compare of both DUTs against the model; also logs beats.
  always @(negedge clk) begin
    int exp_ir;
    if (started) begin
      exp_ir = (!reset && ((qa.size() == 0) || (out_ready && qa[0].last))) ? 1 : 0;
      chk("in_ready_a", int'(in_ready_a), exp_ir);
      chk("in_ready_b", int'(in_ready_b), exp_ir);
      chk("out_valid_a", int'(out_valid_a), (qa.size() != 0) ? 1 : 0);
      chk("out_valid_b", int'(out_valid_b), (qb.size() != 0) ? 1 : 0);
      if (qa.size() != 0) begin
        chk("code_a", int'(out_code_a), int'(qa[0].code));
        chk("last_a", int'(out_last_a), int'(qa[0].last));
        chk("zero_a", int'(out_zero_a), int'(qa[0].zero));
        chk("code_b", int'(out_code_b), int'(qb[0].code));
        chk("last_b", int'(out_last_b), int'(qb[0].last));
        chk("zero_b", int'(out_zero_b), int'(qb[0].zero));
      end
      if (out_valid_a && out_ready) log_a.push_back(int'({out_zero_a, out_last_a, out_code_a}));
      if (out_valid_b && out_ready) log_b.push_back(int'({out_zero_b, out_last_b, out_code_b}));
    end
  end

  // Compare logged beats against hand-computed bytes {zero,last,code}.
  task automatic check_log(input string name, input int n,
                           input logic [63:0] ea, input logic [63:0] eb);
    int act;
    chk({name, "_count_a"}, log_a.size(), n);
    chk({name, "_count_b"}, log_b.size(), n);
    for (int i = 0; i < n; i++) begin
      act = (i < log_a.size()) ? log_a[i] : -1;
      chk({name, "_beat_a"}, act, int'(ea[8*i +: 8]));
      act = (i < log_b.size()) ? log_b[i] : -1;
      chk({name, "_beat_b"}, act, int'(eb[8*i +: 8]));
    end
    log_a.delete();
    log_b.delete();
  endtask

  // Present a vector until accepted; returns 2 time units after the edge.
  task automatic send(input logic [7:0] v);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_vec   = v;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 64) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #2;
      t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((qa.size() != 0 || out_valid_a) && t < 64) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("idle_timeout", (t < 64) ? 1 : 0, 1);
  endtask

  initial begin
    int sel;
    // Reset for two edges, then idle.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", int'(out_valid_a), 0);
    chk("post_reset_code", int'(out_code_a), 0);
    chk("post_reset_ready", int'(in_ready_a), 1);
    chk("post_reset_valid_b", int'(out_valid_b), 0);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    log_a.delete();
    log_b.delete();

    // Single-bit sweep, back to back.
    for (int i = 0; i < 8; i++) send(8'h01 << i);
    wait_idle();
    check_log("sweep", 8, 64'h0F0E0D0C0B0A0908, 64'h0F0E0D0C0B0A0908);

    // Multi-hot vector.
    send(8'hA5);
    wait_idle();
    check_log("multi", 4, 64'h0000_0000_0F05_0200, 64'h0000_0000_0802_0507);

    // Back-pressure after the first beat.
    out_ready = 1'b0;
    send(8'h18);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_code_a", int'(out_code_a), 3);
      chk("bp_code_b", int'(out_code_b), 4);
      chk("bp_in_ready", int'(in_ready_a), 0);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    wait_idle();
    check_log("bp", 2, 64'h0C03, 64'h0B04);

    // Zero vector then a single high bit.
    send(8'h00);
    send(8'h80);
    wait_idle();
    check_log("zero", 2, 64'h0F18, 64'h0F18);

    // Reset after three beats of a full vector.
    send(8'hFF);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_mid_valid", int'(out_valid_a), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_log("rst_mid", 3, 64'h020100, 64'h050607);
    send(8'h10);
    wait_idle();
    check_log("after_rst", 1, 64'h0C, 64'h0C);

    // Randomized traffic with back-pressure and occasional reset.
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      sel      = $urandom_range(0, 3);
      if (sel == 0) in_vec = 8'h00;
      else if (sel == 1) in_vec = 8'h01 << $urandom_range(0, 7);
      else in_vec = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_8_3_serializer.md
Name: encoder_8_3_serializer

Overview:
Inverse companion of the 3-to-8 decoder. Accepts an 8-bit multi-hot vector over a valid/ready handshake and emits one 3-bit binary code per set bit, in priority order, over a second valid/ready handshake. Sits between request-collection logic and any consumer that needs one binary index per beat, such as a decoder or an address mux. A zero vector produces a single flagged beat.

Parameters:
LSB_FIRST, 1, 1 = lowest set bit emitted first; 0 = highest set bit emitted first.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_vec is valid this cycle
in_ready  output  1  block can accept in_vec this cycle
in_vec  input  8  multi-hot request vector
out_valid  output  1  out_code, out_last and out_zero are valid
out_ready  input  1  consumer accepts the current beat
out_code  output  3  binary index of the current set bit
out_last  output  1  current beat is the final beat for this vector
out_zero  output  1  accepted vector was 8'b0; out_code = 3'b000

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - pending <= 0, state <= IDLE.
  - out_valid, out_code, out_last and out_zero are all 0.
  - in_ready = 0 while reset is high.
  - reset overrides any in-flight transfer: the pending vector is discarded and no further beats are emitted for it.
- States:
  - IDLE: no vector held.
  - EMIT: pending register non-empty or a zero-flag beat outstanding.
- in_ready = !reset && (state==IDLE || (out_valid && out_ready && out_last)).
  - This is a combinational pass-through from out_ready.
  - It allows back-to-back vectors with no bubble.
- Accept, when in_valid && in_ready at edge N:
  - in_vec != 0: pending <= in_vec, state <= EMIT.
    - From edge N: out_valid = 1, out_code = priority index of in_vec, out_last = (popcount(in_vec)==1), out_zero = 0.
  - in_vec == 0: one beat from edge N with out_valid = 1, out_code = 3'b000, out_last = 1, out_zero = 1.
  - Latency: first beat is visible one cycle after acceptance.
- Priority index:
  - LSB_FIRST=1: lowest set bit position of pending, e.g. 8'b1010_0100 -> 2.
  - LSB_FIRST=0: highest set bit position, e.g. 8'b1010_0100 -> 7.
- Beat transfer when out_valid && out_ready:
  - The emitted bit is cleared in pending.
  - If remaining pending != 0: out_code and out_last update at the next edge from the remaining bits.
  - If out_last was 1: the vector is complete.
    - If a new vector is accepted on the same edge, the new vector's first beat is visible next cycle.
    - Otherwise state <= IDLE and out_valid <= 0.
- Back-pressure:
  - While out_valid && !out_ready, out_code, out_last and out_zero hold stable.
  - pending is unchanged.
  - in_ready = 0.
- Beat count per vector = max(1, popcount(in_vec)). out_last is asserted exactly once per vector.
- in_vec is sampled only on acceptance. Changes on in_vec while in_ready = 0 are ignored.
- out_valid never drops without a completed transfer, except on reset.

Test Plan:
- Reset then idle: hold reset 2 cycles, release, in_valid = 0 -> out_valid = 0, out_code = 0, in_ready = 1 from the first post-reset cycle.
- Single-bit sweep, LSB_FIRST=1, out_ready = 1: send 8'b0000_0001 through 8'b1000_0000 back-to-back -> codes 0..7 on consecutive cycles, each beat with out_last = 1 and no bubbles.
- Multi-hot: in_vec = 8'b1010_0101, out_ready = 1 -> beats 0, 2, 5, 7 in that order; out_last only on code 7; in_ready = 0 for the first three beats. With LSB_FIRST=0 -> beats 7, 5, 2, 0.
- Back-pressure: in_vec = 8'b0001_1000, out_ready low for 3 cycles after the first beat -> out_code holds at 3 for those cycles and in_ready stays 0. Then raise out_ready -> beats 3, 4 (last).
- Zero vector: in_vec = 8'h00 -> one beat with out_code = 0, out_zero = 1, out_last = 1. Then in_vec = 8'h80 -> a single beat with code 7, out_zero = 0.
- Reset mid-operation: in_vec = 8'hFF, assert reset after 3 beats (codes 0, 1, 2) -> out_valid = 0 next cycle and no further beats. After release, in_vec = 8'h10 -> a single beat with code 4, out_last = 1.
